// File: rtl/sipo_word_assembler.sv
// sipo_word_assembler: collects a serial bit stream into WIDTH-bit words for a PIPO stage.
// Define SIPO_PARITY_EN to expect an even-parity bit after each word before it is loaded.
module sipo_word_assembler #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       SIN,
   input  logic                       SVALID,
   input  logic                       CLR,
   output logic [WIDTH-1:0]           OUT,
   output logic                       LOAD,
   output logic                       BUSY,
   output logic [$clog2(WIDTH+1)-1:0] BIT_CNT,
   output logic                       PERR,
   output logic [1:0]                 DBG_STATE
);
   // Handshake: a bit is taken on every rising CLK edge with SVALID=1 and CLR=0; there is
   // no back-pressure. LOAD is a one-cycle qualifier meaning OUT holds a freshly completed word.

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SIPO_PARITY_EN
   localparam logic [1:0] ST_PAR   = 2'd2;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             load_q, load_d;
   logic             perr_q, perr_d;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      load_d  = 1'b0;
      perr_d  = 1'b0;
      if (MSB_FIRST) shifted = {sreg_q[WIDTH-2:0], SIN};
      else           shifted = {SIN, sreg_q[WIDTH-1:1]};

      // CLR wins over SVALID; the shift register is kept at zero whenever idle.
      if (CLR) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sreg_d  = '0;
      end else if (SVALID) begin
`ifdef SIPO_PARITY_EN
         if (state_q == ST_PAR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
            if ((^sreg_q) == SIN) begin
               out_d  = sreg_q;
               load_d = 1'b1;
            end else begin
               perr_d = 1'b1;
            end
         end else begin
`else
         begin
`endif
            sreg_d = shifted;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
               state_d = ST_PAR;
`else
               state_d = ST_IDLE;
               cnt_d   = '0;
               sreg_d  = '0;
               out_d   = shifted;
               load_d  = 1'b1;
`endif
            end else begin
               state_d = ST_SHIFT;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         load_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         load_q  <= load_d;
         perr_q  <= perr_d;
      end
   end

   assign OUT       = out_q;
   assign LOAD      = load_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign BIT_CNT   = cnt_q;
   assign DBG_STATE = state_q;
`ifdef SIPO_PARITY_EN
   assign PERR      = perr_q;
`else
   assign PERR      = 1'b0;
   logic unused_perr;
   assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: MSB-first and LSB-first instances share one bit stream and
// are compared each cycle against a queue-based word model.
module tb_sipo_word_assembler;
  localparam int W = 4;

  logic CLK, RST, SIN, SVALID, CLR;
  logic [W-1:0] out_m, out_l;
  logic load_m, load_l, busy_m, busy_l, perr_m, perr_l;
  logic [2:0] cnt_m, cnt_l;
  logic [1:0] st_m, st_l;

  int n_vec = 0;
  int n_err = 0;

  // reference model: received bits of the word in progress, oldest first
  logic bits[$];
  logic [W-1:0] exp_out_m, exp_out_l;
  logic exp_load, exp_busy, exp_perr;
  logic [2:0] exp_cnt;

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID), .CLR(CLR),
    .OUT(out_m), .LOAD(load_m), .BUSY(busy_m), .BIT_CNT(cnt_m), .PERR(perr_m), .DBG_STATE(st_m)
  );

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID), .CLR(CLR),
    .OUT(out_l), .LOAD(load_l), .BUSY(busy_l), .BIT_CNT(cnt_l), .PERR(perr_l), .DBG_STATE(st_l)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    bits.delete();
    exp_out_m = '0;
    exp_out_l = '0;
    exp_load  = 1'b0;
    exp_busy  = 1'b0;
    exp_perr  = 1'b0;
    exp_cnt   = '0;
  endtask

  task automatic model_complete();
    for (int i = 0; i < W; i++) begin
      exp_out_m[W-1-i] = bits[i];
      exp_out_l[i]     = bits[i];
    end
    exp_load = 1'b1;
  endtask

  // driver: apply one cycle of inputs, advance past the edge, update the model
  task automatic drive(input logic s, input logic v, input logic c);
    logic p;
    SIN = s; SVALID = v; CLR = c;
    @(posedge CLK);
    #1;
    exp_load = 1'b0;
    exp_perr = 1'b0;
    if (c) begin
      bits.delete();
    end else if (v) begin
`ifdef SIPO_PARITY_EN
      if (bits.size() == W) begin
        p = s;
        foreach (bits[i]) p = p ^ bits[i];
        if (p == 1'b0) model_complete();
        else exp_perr = 1'b1;
        bits.delete();
      end else begin
        bits.push_back(s);
      end
`else
      bits.push_back(s);
      if (bits.size() == W) begin
        model_complete();
        bits.delete();
      end
`endif
    end
    exp_cnt  = 3'(bits.size());
    exp_busy = (bits.size() != 0);
    SIN = 1'b0; SVALID = 1'b0; CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; SIN = 1'b0; SVALID = 1'b0; CLR = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_vec++;
    if ({out_m, load_m, busy_m, cnt_m, perr_m} !== {W'(0), 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_m: got %h exp %h", {out_m, load_m, busy_m, cnt_m, perr_m}, 10'h0);
    end
    n_vec++;
    if ({out_l, load_l, busy_l, cnt_l, perr_l} !== {W'(0), 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_l: got %h exp %h", {out_l, load_l, busy_l, cnt_l, perr_l}, 10'h0);
    end
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({busy_m, cnt_m, load_m} !== 5'd0) begin
      n_err++;
      $display("FAIL reset_idle: got %b exp 00000", {busy_m, cnt_m, load_m});
    end
  endtask

  task automatic test_basic_msb();
    logic [3:0] pat;
    pat = 4'b0101; // bit0 first: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      drive(pat[i], 1'b1, 1'b0);
      n_vec++;
      if ({out_m, load_m, busy_m, cnt_m} !== {exp_out_m, exp_load, exp_busy, exp_cnt}) begin
        n_err++;
        $display("FAIL basic_m[%0d]: got %h exp %h", i, {out_m, load_m, busy_m, cnt_m},
                 {exp_out_m, exp_load, exp_busy, exp_cnt});
      end
    end
    n_vec++;
    if (out_m !== 4'hA || load_m !== 1'b1) begin
      n_err++;
      $display("FAIL basic_word: got out=%h load=%b exp out=a load=1", out_m, load_m);
    end
    n_vec++;
    if (out_l !== 4'h5) begin
      n_err++;
      $display("FAIL basic_lsb_word: got %h exp 5", out_l);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (load_m !== 1'b0 || busy_m !== 1'b0 || out_m !== 4'hA) begin
      n_err++;
      $display("FAIL basic_after: got load=%b busy=%b out=%h exp 0 0 a", load_m, busy_m, out_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    int loads;
    pat = 8'b1000_1011; // bit0 first: 1,1,0,1, 0,0,0,1
    loads = 0;
    for (int i = 0; i < 8; i++) begin
      drive(pat[i], 1'b1, 1'b0);
      if (load_l) loads++;
      n_vec++;
      if ({out_l, load_l, busy_l, cnt_l} !== {exp_out_l, exp_load, exp_busy, exp_cnt}) begin
        n_err++;
        $display("FAIL b2b_l[%0d]: got %h exp %h", i, {out_l, load_l, busy_l, cnt_l},
                 {exp_out_l, exp_load, exp_busy, exp_cnt});
      end
      if (i == 3 || i == 7) begin
        n_vec++;
        if (out_l !== ((i == 3) ? 4'hB : 4'h8) || load_l !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_word[%0d]: got out=%h load=%b exp %h 1", i, out_l, load_l,
                   (i == 3) ? 4'hB : 4'h8);
        end
      end
    end
    n_vec++;
    if (loads !== 2) begin
      n_err++;
      $display("FAIL b2b_loads: got %0d exp 2", loads);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] pat;
    int loads;
    pat = 4'b1010; // bit0 first: 0,1,0,1 -> 5 MSB-first
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      drive(pat[i], 1'b1, 1'b0);
      if (load_m) loads++;
      for (int g = 0; g < ((i < 3) ? 3 : 1); g++) begin
        n_vec++;
        if ({cnt_m, busy_m, out_m} !== {exp_cnt, exp_busy, exp_out_m}) begin
          n_err++;
          $display("FAIL gap_cnt[%0d.%0d]: got %h exp %h", i, g, {cnt_m, busy_m, out_m},
                   {exp_cnt, exp_busy, exp_out_m});
        end
        if (i < 3) begin
          drive(1'b0, 1'b0, 1'b0);
          if (load_m) loads++;
        end
      end
    end
    n_vec++;
    if (out_m !== 4'h5 || loads !== 1) begin
      n_err++;
      $display("FAIL gap_word: got out=%h loads=%0d exp 5 1", out_m, loads);
    end
  endtask

  task automatic test_abort();
    logic [3:0] pat;
    pat = 4'b0111; // 1,1,1,0 -> E
    for (int i = 0; i < 4; i++) drive(pat[i], 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({cnt_m, busy_m, out_m, load_m} !== {3'd0, 1'b0, 4'hE, 1'b0}) begin
      n_err++;
      $display("FAIL abort: got cnt=%0d busy=%b out=%h load=%b exp 0 0 e 0", cnt_m, busy_m,
               out_m, load_m);
    end
    drive(1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({cnt_m, busy_m, out_m, load_m} !== {exp_cnt, exp_busy, exp_out_m, exp_load}) begin
      n_err++;
      $display("FAIL abort_idle_clr: got %h exp %h", {cnt_m, busy_m, out_m, load_m},
               {exp_cnt, exp_busy, exp_out_m, exp_load});
    end
    pat = 4'b0010; // 0,1,0,0 -> 4
    for (int i = 0; i < 4; i++) drive(pat[i], 1'b1, 1'b0);
    n_vec++;
    if (out_m !== 4'h4 || load_m !== 1'b1) begin
      n_err++;
      $display("FAIL abort_next: got out=%h load=%b exp 4 1", out_m, load_m);
    end
  endtask

  task automatic test_async_reset();
    int loads;
    loads = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({out_m, load_m, busy_m, cnt_m, out_l, busy_l, cnt_l} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got m=%h l=%h exp 0", {out_m, load_m, busy_m, cnt_m},
               {out_l, busy_l, cnt_l});
    end
    #2;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (load_m || load_l) loads++;
    end
    n_vec++;
    if (loads !== 0 || out_m !== 4'h0) begin
      n_err++;
      $display("FAIL async_release: got loads=%0d out=%h exp 0 0", loads, out_m);
    end
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic [4:0] pat;
    pat = 5'b11101; // 1,0,1,1 then parity 1
    for (int i = 0; i < 5; i++) drive(pat[i], 1'b1, 1'b0);
    n_vec++;
    if (out_m !== 4'hB || load_m !== 1'b1 || perr_m !== 1'b0) begin
      n_err++;
      $display("FAIL parity_good: got out=%h load=%b perr=%b exp b 1 0", out_m, load_m, perr_m);
    end
    pat = 5'b01101; // same data, parity 0
    for (int i = 0; i < 5; i++) drive(pat[i], 1'b1, 1'b0);
    n_vec++;
    if (out_m !== 4'hB || load_m !== 1'b0 || perr_m !== 1'b1) begin
      n_err++;
      $display("FAIL parity_bad: got out=%h load=%b perr=%b exp b 0 1", out_m, load_m, perr_m);
    end
  endtask
`endif

  task automatic test_random();
    logic s, v, c;
    for (int i = 0; i < 400; i++) begin
      s = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      drive(s, v, c);
      n_vec++;
      if ({out_m, load_m, busy_m, cnt_m, perr_m} !==
          {exp_out_m, exp_load, exp_busy, exp_cnt, exp_perr}) begin
        n_err++;
        $display("FAIL rand_m[%0d]: got %h exp %h", i, {out_m, load_m, busy_m, cnt_m, perr_m},
                 {exp_out_m, exp_load, exp_busy, exp_cnt, exp_perr});
      end
      n_vec++;
      if ({out_l, load_l, busy_l, cnt_l, perr_l} !==
          {exp_out_l, exp_load, exp_busy, exp_cnt, exp_perr}) begin
        n_err++;
        $display("FAIL rand_l[%0d]: got %h exp %h", i, {out_l, load_l, busy_l, cnt_l, perr_l},
                 {exp_out_l, exp_load, exp_busy, exp_cnt, exp_perr});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_msb();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_async_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Serial-in, parallel-out front end for the 4-bit PIPO register stage.
- Collects a serial bit stream into WIDTH-bit words.
- Presents each completed word on OUT, with a one-cycle LOAD pulse that drives the downstream register's Load input directly.
- Holds the last good word stable between completions, so the downstream stage samples a clean value.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in OUT[WIDTH-1]; 0 = first bit lands in OUT[0].

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- SIN  input  1  serial data bit.
- SVALID  input  1  bit strobe; SIN is sampled on any CLK edge where SVALID=1.
- CLR  input  1  synchronous abort of the partial word.
- OUT  output  WIDTH  last completed word.
- LOAD  output  1  one-cycle pulse; OUT is new this cycle.
- BUSY  output  1  1 while a partial word is held (state SHIFT or PAR).
- BIT_CNT  output  clog2(WIDTH+1)  data bits accepted into the current word.
- PERR  output  1  parity error pulse; only meaningful with the optional feature.

Behaviour:
- Clocking: one clock, CLK. RST is asynchronous and active-high. All state is updated on CLK rising edges.
- Reset values: OUT=0, LOAD=0, BUSY=0, BIT_CNT=0, PERR=0, internal shift register=0, state=IDLE.
- States: IDLE, SHIFT, PAR. PAR exists only with the optional feature.
- IDLE:
  - SVALID=1 -> bit accepted, BIT_CNT=1, go to SHIFT.
  - SVALID=0 -> stay.
- SHIFT:
  - Each SVALID=1 accepts one bit and increments BIT_CNT.
  - MSB_FIRST=1: shift register shifts left, bit enters LSB.
  - MSB_FIRST=0: shift register shifts right, bit enters MSB.
  - Final word ordering: the first bit ends up at the position set by MSB_FIRST.
- Completion:
  - On the edge accepting the WIDTH-th bit: OUT <= completed word, LOAD <= 1, BIT_CNT <= 0, state <= IDLE.
  - Latency: OUT and LOAD are valid in the cycle after the last bit is sampled.
- LOAD timing:
  - High for exactly one cycle per completed word.
  - Never asserted for a partial or aborted word.
- Back-to-back words: SVALID=1 in the cycle LOAD is high is accepted as bit 0 of the next word. No bubble is required; sustained 1 bit/cycle is supported.
- SVALID gaps: unlimited. The partial word and BIT_CNT are held.
- CLR:
  - Priority over SVALID in the same cycle; that cycle's bit is discarded.
  - Next state IDLE, BIT_CNT=0, shift register cleared.
  - OUT is unchanged and LOAD=0.
  - CLR in IDLE is a no-op.
- RST mid-word: everything returns to its reset value immediately, including OUT=0.
- BUSY = (state != IDLE).

Optional Feature:
- Macro: SIPO_PARITY_EN.
- With the macro defined:
  - After the WIDTH-th data bit, the state moves to PAR instead of completing. OUT and LOAD are not updated yet.
  - The next SVALID bit is an even-parity bit: XOR of the data bits and the parity bit must equal 0.
  - Parity good -> OUT updated, LOAD pulses one cycle.
  - Parity bad -> OUT unchanged, LOAD=0, PERR pulses one cycle.
  - Either way the state returns to IDLE.
  - BIT_CNT stays at WIDTH while in PAR.
  - CLR in PAR aborts as in SHIFT.
- Without the macro: no PAR state, PERR tied to 0, and the word completes on the WIDTH-th bit.

Test Plan:
- Basic MSB-first word: WIDTH=4, MSB_FIRST=1; bits 1,0,1,0 on consecutive cycles -> OUT=4'hA in the cycle after the 4th bit; LOAD high exactly 1 cycle; BUSY low afterwards.
- Back-to-back with LSB-first: MSB_FIRST=0; 8 continuous bits 1,1,0,1, 0,0,0,1 -> OUT=4'hB with LOAD, then OUT=4'h8 with LOAD exactly 4 cycles later; no lost bit.
- Gapped strobes: bits of 4'h5 with 3 idle cycles between each -> BIT_CNT steps 1,2,3 and holds during gaps; OUT=4'h5 after the final bit; single LOAD pulse.
- Abort: OUT=4'hE loaded; send 2 bits; CLR asserted together with SVALID -> BIT_CNT=0, BUSY=0, OUT stays 4'hE, no LOAD; the next 4 bits of 4'h4 give OUT=4'h4.
- Async reset: assert RST between CLK edges after 3 bits -> all outputs 0 immediately, with no LOAD on release.
- Parity (SIPO_PARITY_EN): data 1,0,1,1 then parity 1 -> OUT=4'hB and LOAD. Same data with parity 0 -> PERR pulse, OUT unchanged, LOAD=0.
